wb_queue: RTL and testbench

write-back producer for the register-file write port; 2-entry in-order queue between the MEM stage and the RF, with bypass to the RF read ports.

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have ports in_valid input 1 and in_ready output 1, the MEM-side handshake; transfer occurs when both are high at a rising edge.
REQ-004 SHALL have ports in_wR input 5, in_wsel input 3, in_pc4 input 32, in_sext input 32, in_alu_c input 32, the destination, selector (WB_ALU/WB_EXT/WB_DRAM/WB_PC4 from defines.vh) and candidate data.
REQ-005 SHALL have ports dram_valid input 1 and dram_rdo input 32, load data returning after enqueue.
REQ-006 SHALL have port wb_hold input 1, which blocks the write port this cycle.
REQ-007 SHALL have outputs rf_we 1, rf_wR 5, rf_wD 32, driving the RF write port.
REQ-008 SHALL have inputs rR1 5 and rR2 5, and outputs fwd1_hit 1, fwd1_data 32, fwd2_hit 1, fwd2_data 32, and raw_stall 1.
REQ-009 SHALL have outputs count 2 (entries held, 0..2) and debug_wb_value 32 (equal to rf_wD).

Function
REQ-010 Entry fields: valid, wR, data (32), done; on enqueue data = in_alu_c/in_sext/in_pc4 per in_wsel, done=1; WB_DRAM sets done=0; unknown in_wsel behaves as WB_ALU.
REQ-011 dram_valid high at an edge SHALL write dram_rdo into the oldest entry with done=0 and set its done; dram_valid with no such entry is ignored.
REQ-012 in_ready SHALL be (count<2) OR (a drain occurs this cycle); enqueue and drain in the same cycle keep count constant.
REQ-013 Drain condition: head valid AND head done AND NOT wb_hold; then rf_we=1 (or 0 if head wR==0), rf_wR=head wR, rf_wD=head data, and the head is popped at the edge.
REQ-014 Entries with wR==0 SHALL still be queued, completed and popped, never asserting rf_we.
REQ-015 When no drain occurs rf_we=0 and rf_wR/rf_wD SHALL hold the head fields (zero when empty).
REQ-016 Write latency: an ALU/EXT/PC4 entry enqueued into an empty queue at edge N SHALL appear on rf_we in cycle N+1 (wb_hold low).
REQ-017 A DRAM entry whose dram_valid arrives at edge M SHALL drain no earlier than cycle M+1; dram_valid in the enqueue cycle applies only to entries already held.
REQ-018 Ordering strictly FIFO; a completed younger entry SHALL NOT drain before an incomplete head.
REQ-019 count SHALL never exceed 2; enqueue when full and not draining is impossible since in_ready=0.

Reset
REQ-020 rst high at an edge SHALL clear all entries, count=0, rf_we=0, rf_wR=0, rf_wD=0, fwd hits=0, raw_stall=0, discarding pending loads and the in-flight transfer.
REQ-021 dram_valid or in_valid coincident with rst SHALL be ignored; in_ready is 1 in the first cycle after reset.

Configuration
REQ-022 Macro WB_QUEUE_FWD_EN defined: for each read port the youngest valid entry with wR==rRx and wR!=0 is matched; if done, fwdx_hit=1 and fwdx_data=its data; if not done, raw_stall=1.
REQ-023 WB_QUEUE_FWD_EN undefined: fwd hits and data tie to 0; raw_stall=1 whenever any valid entry with nonzero wR matches rR1 or rR2.

Verification
REQ-024 Reset, then enqueue ALU wR=5 alu_c=0x1234 -> next cycle rf_we=1, rf_wR=5, rf_wD=0x1234, count back to 0.
REQ-025 Enqueue DRAM wR=7, then ALU wR=8 0xAA; dram_valid with 0xDEADBEEF 3 cycles later -> wR7=0xDEADBEEF written first, wR8=0xAA next cycle.
REQ-026 wb_hold high, enqueue 2 entries -> in_ready=0, count=2, rf_we=0; drop wb_hold -> one write per cycle in order, in_ready=1 that cycle.
REQ-027 Enqueue PC4 wR=0 pc4=0x40 -> popped, rf_we stays 0.
REQ-028 FWD_EN: enqueue ALU wR=3 0x55 with wb_hold high, rR1=3 -> fwd1_hit=1, fwd1_data=0x55; pending DRAM wR=3 instead -> raw_stall=1.
REQ-029 Two entries queued, pending load, rst at next edge -> all outputs zero; late dram_valid afterwards -> no write.

---
 rtl/wb_queue_if.sv | 36 +++
 rtl/wb_queue.sv | 188 ++++++++++++++++++
 tb/tb_wb_queue.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue_if
// Brief    : MEM-stage to write-back queue handshake and candidate-data bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_wR;
   logic [2:0]  in_wsel;
   logic [31:0] in_pc4;
   logic [31:0] in_sext;
   logic [31:0] in_alu_c;

   modport master (
      output in_valid,
      output in_wR,
      output in_wsel,
      output in_pc4,
      output in_sext,
      output in_alu_c,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_wR,
      input  in_wsel,
      input  in_pc4,
      input  in_sext,
      input  in_alu_c,
      output in_ready
   );
endinterface
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Brief    : 2-entry in-order write-back queue feeding the RF write port, with
//            lookup of queued results for the RF read ports.
//            Optional feature macro: WB_QUEUE_FWD_EN (forwarding of completed
//            entries; otherwise any match raises raw_stall).
// Revision : 1.0 - initial release
// ============================================================================
module wb_queue (
   input  logic        clk,
   input  logic        rst,
   wb_queue_if.slave   mem,
   input  logic        dram_valid,
   input  logic [31:0] dram_rdo,
   input  logic        wb_hold,
   output logic        rf_we,
   output logic [4:0]  rf_wR,
   output logic [31:0] rf_wD,
   input  logic [4:0]  rR1,
   input  logic [4:0]  rR2,
   output logic        fwd1_hit,
   output logic [31:0] fwd1_data,
   output logic        fwd2_hit,
   output logic [31:0] fwd2_data,
   output logic        raw_stall,
   output logic [1:0]  count,
   output logic [31:0] debug_wb_value
);

   localparam logic [2:0] c_WB_ALU  = 3'd0;
   localparam logic [2:0] c_WB_EXT  = 3'd1;
   localparam logic [2:0] c_WB_DRAM = 3'd2;
   localparam logic [2:0] c_WB_PC4  = 3'd3;

   // Slot 0 is always the head; slot 1 is only valid when slot 0 is.
   logic [1:0]  r_valid;
   logic [1:0]  r_done;
   logic [4:0]  r_wr   [2];
   logic [31:0] r_data [2];

   logic [1:0]  w_valid_n;
   logic [1:0]  w_done_n;
   logic [4:0]  w_wr_n   [2];
   logic [31:0] w_data_n [2];

   logic        w_drain;
   logic        w_push;
   logic        w_in_ready;
   logic [31:0] w_enq_data;
   logic        w_enq_done;
   logic [4:0]  w_rr [2];
   logic [1:0]  w_match;

   assign count      = {1'b0, r_valid[0]} + {1'b0, r_valid[1]};
   assign w_drain    = r_valid[0] & r_done[0] & ~wb_hold;
   assign w_in_ready = (count != 2'd2) | w_drain;
   assign w_push     = mem.in_valid & w_in_ready;
   assign mem.in_ready = w_in_ready;

   assign rf_we          = w_drain & (r_wr[0] != 5'd0);
   assign rf_wR          = r_valid[0] ? r_wr[0]   : 5'd0;
   assign rf_wD          = r_valid[0] ? r_data[0] : 32'd0;
   assign debug_wb_value = rf_wD;

   always_comb begin
      w_enq_data = mem.in_alu_c;
      w_enq_done = 1'b1;
      case (mem.in_wsel)
         c_WB_ALU:  w_enq_data = mem.in_alu_c;
         c_WB_EXT:  w_enq_data = mem.in_sext;
         c_WB_PC4:  w_enq_data = mem.in_pc4;
         c_WB_DRAM: begin
            w_enq_data = 32'd0;
            w_enq_done = 1'b0;
         end
         default:   w_enq_data = mem.in_alu_c;
      endcase
   end

   // Order matters: load return lands on held entries, then pop, then push.
   always_comb begin
      w_valid_n = r_valid;
      w_done_n  = r_done;
      w_wr_n    = r_wr;
      w_data_n  = r_data;

      if (dram_valid) begin
         if (r_valid[0] && !r_done[0]) begin
            w_data_n[0] = dram_rdo;
            w_done_n[0] = 1'b1;
         end else if (r_valid[1] && !r_done[1]) begin
            w_data_n[1] = dram_rdo;
            w_done_n[1] = 1'b1;
         end
      end

      if (w_drain) begin
         w_valid_n[0] = w_valid_n[1];
         w_done_n[0]  = w_done_n[1];
         w_wr_n[0]    = w_wr_n[1];
         w_data_n[0]  = w_data_n[1];
         w_valid_n[1] = 1'b0;
         w_done_n[1]  = 1'b0;
         w_wr_n[1]    = 5'd0;
         w_data_n[1]  = 32'd0;
      end

      if (w_push) begin
         if (!w_valid_n[0]) begin
            w_valid_n[0] = 1'b1;
            w_done_n[0]  = w_enq_done;
            w_wr_n[0]    = mem.in_wR;
            w_data_n[0]  = w_enq_data;
         end else begin
            w_valid_n[1] = 1'b1;
            w_done_n[1]  = w_enq_done;
            w_wr_n[1]    = mem.in_wR;
            w_data_n[1]  = w_enq_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 2'b00;
         r_done  <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            r_wr[i]   <= 5'd0;
            r_data[i] <= 32'd0;
         end
      end else begin
         r_valid <= w_valid_n;
         r_done  <= w_done_n;
         for (int i = 0; i < 2; i++) begin
            r_wr[i]   <= w_wr_n[i];
            r_data[i] <= w_data_n[i];
         end
      end
   end

   assign w_rr[0] = rR1;
   assign w_rr[1] = rR2;

`ifdef WB_QUEUE_FWD_EN
   logic [1:0]  w_mdone;
   logic [31:0] w_mdata [2];

   // Slot 1 is younger, so it wins when both slots hold the same register.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_match[p] = 1'b0;
         w_mdone[p] = 1'b0;
         w_mdata[p] = 32'd0;
         if (r_valid[1] && (r_wr[1] != 5'd0) && (r_wr[1] == w_rr[p])) begin
            w_match[p] = 1'b1;
            w_mdone[p] = r_done[1];
            w_mdata[p] = r_data[1];
         end else if (r_valid[0] && (r_wr[0] != 5'd0) && (r_wr[0] == w_rr[p])) begin
            w_match[p] = 1'b1;
            w_mdone[p] = r_done[0];
            w_mdata[p] = r_data[0];
         end
      end
   end

   assign fwd1_hit  = w_match[0] & w_mdone[0];
   assign fwd1_data = fwd1_hit ? w_mdata[0] : 32'd0;
   assign fwd2_hit  = w_match[1] & w_mdone[1];
   assign fwd2_data = fwd2_hit ? w_mdata[1] : 32'd0;
   assign raw_stall = (w_match[0] & ~w_mdone[0]) | (w_match[1] & ~w_mdone[1]);
`else
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_match[p] = (r_valid[0] && (r_wr[0] != 5'd0) && (r_wr[0] == w_rr[p])) ||
                      (r_valid[1] && (r_wr[1] != 5'd0) && (r_wr[1] == w_rr[p]));
      end
   end

   assign fwd1_hit  = 1'b0;
   assign fwd1_data = 32'd0;
   assign fwd2_hit  = 1'b0;
   assign fwd2_data = 32'd0;
   assign raw_stall = |w_match;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_queue
// Brief    : Self-checking bench for wb_queue with an in-order write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_queue;
   localparam logic [2:0] WB_ALU  = 3'd0;
   localparam logic [2:0] WB_EXT  = 3'd1;
   localparam logic [2:0] WB_DRAM = 3'd2;
   localparam logic [2:0] WB_PC4  = 3'd3;

   typedef struct {
      logic [4:0]  wr;
      logic [31:0] data;
      bit          pending;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        dram_valid;
   logic [31:0] dram_rdo;
   logic        wb_hold;
   logic        rf_we;
   logic [4:0]  rf_wR;
   logic [31:0] rf_wD;
   logic [4:0]  rR1, rR2;
   logic        fwd1_hit, fwd2_hit;
   logic [31:0] fwd1_data, fwd2_data;
   logic        raw_stall;
   logic [1:0]  count;
   logic [31:0] debug_wb_value;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   exp_t m_exp;

   wb_queue_if bus ();

   wb_queue dut (
      .clk            (clk),
      .rst            (rst),
      .mem            (bus),
      .dram_valid     (dram_valid),
      .dram_rdo       (dram_rdo),
      .wb_hold        (wb_hold),
      .rf_we          (rf_we),
      .rf_wR          (rf_wR),
      .rf_wD          (rf_wD),
      .rR1            (rR1),
      .rR2            (rR2),
      .fwd1_hit       (fwd1_hit),
      .fwd1_data      (fwd1_data),
      .fwd2_hit       (fwd2_hit),
      .fwd2_data      (fwd2_data),
      .raw_stall      (raw_stall),
      .count          (count),
      .debug_wb_value (debug_wb_value)
   );

   always #5 clk = ~clk;

   // Every RF write must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got write wR=%0d wD=%h, want no write", rf_wR, rf_wD);
         end else begin
            m_exp = sb.pop_front();
            if (m_exp.pending || rf_wR !== m_exp.wr || rf_wD !== m_exp.data || debug_wb_value !== rf_wD) begin
               n_fail++;
               $display("FAIL sb_write: got wR=%0d wD=%h dbg=%h, want wR=%0d wD=%h (pending=%0d)",
                        rf_wR, rf_wD, debug_wb_value, m_exp.wr, m_exp.data, m_exp.pending);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic clr_in();
      bus.in_valid = 1'b0;
      dram_valid   = 1'b0;
   endtask

   task automatic set_enq(input logic [4:0] wr, input logic [2:0] sel, input logic [31:0] v);
      exp_t e;
      bus.in_valid = 1'b1;
      bus.in_wR    = wr;
      bus.in_wsel  = sel;
      bus.in_alu_c = ~v;
      bus.in_sext  = v ^ 32'h5A5A_0000;
      bus.in_pc4   = v + 32'h100;
      case (sel)
         WB_EXT:  bus.in_sext  = v;
         WB_PC4:  bus.in_pc4   = v;
         WB_DRAM: ;
         default: bus.in_alu_c = v;
      endcase
      e.wr      = wr;
      e.data    = v;
      e.pending = (sel == WB_DRAM);
      if (wr != 5'd0) sb.push_back(e);
   endtask

   task automatic set_dram(input logic [31:0] v);
      exp_t e;
      dram_valid = 1'b1;
      dram_rdo   = v;
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].pending) begin
            e = sb[i];
            e.data = v;
            e.pending = 1'b0;
            sb[i] = e;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_enq(5'd4, WB_ALU, 32'h0BAD);
      sb.delete();
      dram_valid = 1'b1;
      dram_rdo   = 32'hFFFF_FFFF;
      cycle();
      cycle();
      rst = 1'b0;
      clr_in();
      sample();
      n_checks++;
      if (count !== 2'd0 || rf_we !== 1'b0 || rf_wR !== 5'd0 || rf_wD !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got count=%0d we=%b wR=%0d wD=%h, want 0/0/0/0", count, rf_we, rf_wR, rf_wD);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1 || raw_stall !== 1'b0 || fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got ready=%b stall=%b h1=%b h2=%b, want 1/0/0/0", bus.in_ready, raw_stall, fwd1_hit, fwd2_hit);
      end
   endtask

   task automatic test_alu();
      cycle();
      set_enq(5'd5, WB_ALU, 32'h1234);
      sample();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL alu_ready: got %b want 1", bus.in_ready);
      end
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (rf_we !== 1'b1 || rf_wR !== 5'd5 || rf_wD !== 32'h1234 || count !== 2'd1) begin
         n_fail++;
         $display("FAIL alu_write: got we=%b wR=%0d wD=%h count=%0d, want 1/5/00001234/1", rf_we, rf_wR, rf_wD, count);
      end
      cycle();
      sample();
      n_checks++;
      if (count !== 2'd0 || rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_empty: got count=%0d we=%b, want 0/0", count, rf_we);
      end
   endtask

   task automatic test_back_to_back();
      cycle();
      set_enq(5'd9, WB_EXT, 32'hFFFF_FF80);
      cycle();
      set_enq(5'd10, WB_PC4, 32'h0000_0104);
      sample();
      n_checks++;
      if (bus.in_ready !== 1'b1 || rf_we !== 1'b1 || rf_wR !== 5'd9) begin
         n_fail++;
         $display("FAIL b2b_overlap: got ready=%b we=%b wR=%0d, want 1/1/9", bus.in_ready, rf_we, rf_wR);
      end
      cycle();
      set_enq(5'd11, 3'd7, 32'h0000_CAFE);
      cycle();
      clr_in();
      cycle();
      sample();
      n_checks++;
      if (count !== 2'd0) begin
         n_fail++;
         $display("FAIL b2b_drained: got count=%0d want 0", count);
      end
   endtask

   task automatic test_dram();
      cycle();
      set_enq(5'd7, WB_DRAM, 32'd0);
      cycle();
      set_enq(5'd8, WB_ALU, 32'hAA);
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (count !== 2'd2 || rf_we !== 1'b0 || bus.in_ready !== 1'b0 || rf_wR !== 5'd7) begin
         n_fail++;
         $display("FAIL dram_wait: got count=%0d we=%b ready=%b wR=%0d, want 2/0/0/7", count, rf_we, bus.in_ready, rf_wR);
      end
      cycle();
      cycle();
      set_dram(32'hDEAD_BEEF);
      sample();
      n_checks++;
      if (rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL dram_early: got we=%b want 0", rf_we);
      end
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (rf_we !== 1'b1 || rf_wR !== 5'd7 || rf_wD !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL dram_first: got we=%b wR=%0d wD=%h, want 1/7/deadbeef", rf_we, rf_wR, rf_wD);
      end
      cycle();
      sample();
      n_checks++;
      if (rf_we !== 1'b1 || rf_wR !== 5'd8 || rf_wD !== 32'hAA) begin
         n_fail++;
         $display("FAIL dram_second: got we=%b wR=%0d wD=%h, want 1/8/000000aa", rf_we, rf_wR, rf_wD);
      end
      // Load data in the enqueue cycle must not complete the new entry.
      cycle();
      set_dram(32'h111);
      set_enq(5'd12, WB_DRAM, 32'd0);
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (rf_we !== 1'b0 || count !== 2'd1) begin
         n_fail++;
         $display("FAIL dram_same_cycle: got we=%b count=%0d, want 0/1", rf_we, count);
      end
      cycle();
      set_dram(32'h222);
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (rf_we !== 1'b1 || rf_wD !== 32'h222) begin
         n_fail++;
         $display("FAIL dram_late_fill: got we=%b wD=%h, want 1/00000222", rf_we, rf_wD);
      end
      cycle();
   endtask

   task automatic test_hold();
      cycle();
      wb_hold = 1'b1;
      set_enq(5'd13, WB_ALU, 32'h13);
      cycle();
      set_enq(5'd14, WB_EXT, 32'h14);
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (bus.in_ready !== 1'b0 || count !== 2'd2 || rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_full: got ready=%b count=%0d we=%b, want 0/2/0", bus.in_ready, count, rf_we);
      end
      cycle();
      wb_hold = 1'b0;
      set_enq(5'd15, WB_PC4, 32'h15);
      sample();
      n_checks++;
      if (rf_we !== 1'b1 || rf_wR !== 5'd13 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_release: got we=%b wR=%0d ready=%b, want 1/13/1", rf_we, rf_wR, bus.in_ready);
      end
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (count !== 2'd2 || rf_wR !== 5'd14) begin
         n_fail++;
         $display("FAIL hold_swap: got count=%0d wR=%0d, want 2/14", count, rf_wR);
      end
      cycle();
      cycle();
      sample();
      n_checks++;
      if (count !== 2'd0) begin
         n_fail++;
         $display("FAIL hold_drained: got count=%0d want 0", count);
      end
   endtask

   task automatic test_zero_dest();
      cycle();
      set_enq(5'd0, WB_PC4, 32'h40);
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (rf_we !== 1'b0 || rf_wR !== 5'd0 || rf_wD !== 32'h40 || count !== 2'd1) begin
         n_fail++;
         $display("FAIL zero_head: got we=%b wR=%0d wD=%h count=%0d, want 0/0/00000040/1", rf_we, rf_wR, rf_wD, count);
      end
      cycle();
      sample();
      n_checks++;
      if (count !== 2'd0) begin
         n_fail++;
         $display("FAIL zero_popped: got count=%0d want 0", count);
      end
   endtask

   task automatic test_fwd();
      logic exp_hit;
      exp_hit = 1'b0;
`ifdef WB_QUEUE_FWD_EN
      exp_hit = 1'b1;
`endif
      cycle();
      wb_hold = 1'b1;
      rR1 = 5'd3;
      rR2 = 5'd4;
      set_enq(5'd3, WB_ALU, 32'h55);
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (fwd1_hit !== exp_hit || fwd1_data !== (exp_hit ? 32'h55 : 32'h0) || raw_stall !== ~exp_hit || fwd2_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL fwd_done: got h1=%b d1=%h stall=%b h2=%b, want h1=%b stall=%b h2=0",
                  fwd1_hit, fwd1_data, raw_stall, fwd2_hit, exp_hit, ~exp_hit);
      end
      cycle();
      rR2 = 5'd3;
      set_enq(5'd3, WB_ALU, 32'h66);
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (fwd2_hit !== exp_hit || fwd2_data !== (exp_hit ? 32'h66 : 32'h0) || raw_stall !== ~exp_hit) begin
         n_fail++;
         $display("FAIL fwd_youngest: got h2=%b d2=%h stall=%b, want h2=%b stall=%b", fwd2_hit, fwd2_data, raw_stall, exp_hit, ~exp_hit);
      end
      cycle();
      wb_hold = 1'b0;
      cycle();
      cycle();
      sample();
      n_checks++;
      if (count !== 2'd0 || raw_stall !== 1'b0 || fwd1_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL fwd_clear: got count=%0d stall=%b h1=%b, want 0/0/0", count, raw_stall, fwd1_hit);
      end
      cycle();
      set_enq(5'd3, WB_DRAM, 32'd0);
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (raw_stall !== 1'b1 || fwd1_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL fwd_pending: got stall=%b h1=%b, want 1/0", raw_stall, fwd1_hit);
      end
      cycle();
      set_dram(32'h99);
      cycle();
      clr_in();
      sample();
      n_checks++;
      if (fwd1_hit !== exp_hit || fwd1_data !== (exp_hit ? 32'h99 : 32'h0) || raw_stall !== ~exp_hit) begin
         n_fail++;
         $display("FAIL fwd_filled: got h1=%b d1=%h stall=%b, want h1=%b stall=%b", fwd1_hit, fwd1_data, raw_stall, exp_hit, ~exp_hit);
      end
      cycle();
      rR1 = 5'd0;
      rR2 = 5'd0;
   endtask

   task automatic test_reset_flush();
      cycle();
      wb_hold = 1'b1;
      rR1 = 5'd20;
      set_enq(5'd20, WB_DRAM, 32'd0);
      cycle();
      set_enq(5'd21, WB_ALU, 32'h21);
      cycle();
      clr_in();
      rst = 1'b1;
      sample();
      n_checks++;
      if (count !== 2'd2 || raw_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_before: got count=%0d stall=%b, want 2/1", count, raw_stall);
      end
      cycle();
      rst = 1'b0;
      wb_hold = 1'b0;
      sb.delete();
      sample();
      n_checks++;
      if (count !== 2'd0 || rf_we !== 1'b0 || rf_wR !== 5'd0 || rf_wD !== 32'd0 || raw_stall !== 1'b0 || fwd1_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_after: got count=%0d we=%b wR=%0d wD=%h stall=%b h1=%b, want all 0",
                  count, rf_we, rf_wR, rf_wD, raw_stall, fwd1_hit);
      end
      cycle();
      dram_valid = 1'b1;
      dram_rdo   = 32'hBAD0_BAD0;
      cycle();
      clr_in();
      cycle();
      cycle();
      sample();
      n_checks++;
      if (count !== 2'd0 || rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_late_load: got count=%0d we=%b, want 0/0", count, rf_we);
      end
      rR1 = 5'd0;
   endtask

   initial begin
      rst          = 1'b1;
      wb_hold      = 1'b0;
      dram_valid   = 1'b0;
      dram_rdo     = 32'd0;
      rR1          = 5'd0;
      rR2          = 5'd0;
      bus.in_valid = 1'b0;
      bus.in_wR    = 5'd0;
      bus.in_wsel  = 3'd0;
      bus.in_pc4   = 32'd0;
      bus.in_sext  = 32'd0;
      bus.in_alu_c = 32'd0;

      test_reset();
      test_alu();
      test_back_to_back();
      test_dram();
      test_hold();
      test_zero_dest();
      test_fwd();
      test_reset_flush();

      cycle();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d outstanding writes, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
